// File: rtl/branch_target_buffer.sv
// -----------------------------------------------------------------------------
// branch_target_buffer
//
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// The fetch side gets one PC lookup per cycle with a registered prediction. The
// resolution side trains the table from the branch unit's br_results packet.
// After reset an init sweep clears every valid bit, one entry per cycle, before
// lookups and training are accepted.
//
// Optional feature macro: BTB_RAS_EN adds a RAS_DEPTH-entry circular return
// stack. Calls push and returns pop at resolution, and return hits predict
// the stack top.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   init_done       table sweep finished; lookups are valid
//   fetch_req       lookup request this cycle
//   fetch_pc        PC to look up
//   pred_valid      prediction for the previous cycle's request is present
//   pred_hit        tag match on a valid entry
//   pred_taken      predicted redirect
//   pred_target     predicted target (0 on miss)
//   pred_is_return  hit entry is a return
//   br_results      branch resolution packet (training input)
// -----------------------------------------------------------------------------
package btb_pkg;
  typedef struct packed {
    logic        valid;
    logic [3:0]  id;
    logic [31:0] pc;
    logic [31:0] target_pc;
    logic        branch_taken;
    logic        is_branch;
    logic        is_return;
    logic        is_call;
  } branch_results_t;
endpackage

module branch_target_buffer
  import btb_pkg::*;
#(
  parameter int ENTRIES   = 512,
  parameter int TAG_W     = 8,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic            init_done,
  input  logic            fetch_req,
  input  logic [31:0]     fetch_pc,
  output logic            pred_valid,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [31:0]     pred_target,
  output logic            pred_is_return,
  input  branch_results_t br_results
);

  localparam int IDX_W = $clog2(ENTRIES);

  typedef enum logic {INIT, RUN} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   sweep_cnt, sweep_nxt;
  logic               clear_en;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= INIT;
      sweep_cnt <= '0;
    end else begin
      state     <= state_nxt;
      sweep_cnt <= sweep_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    sweep_nxt = sweep_cnt;
    clear_en  = 1'b0;
    case (state)
      INIT: begin
        clear_en  = 1'b1;
        sweep_nxt = sweep_cnt + 1'b1;  // wraps to 0 on the last entry
        if (sweep_cnt == IDX_W'(ENTRIES - 1)) state_nxt = RUN;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------- table
  logic             v_tab   [ENTRIES];
  logic [TAG_W-1:0] tag_tab [ENTRIES];
  logic [30:0]      tgt_tab [ENTRIES];
  logic [1:0]       ctr_tab [ENTRIES];
  logic             br_tab  [ENTRIES];
  logic             ret_tab [ENTRIES];

  // Fetch read port.
  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  logic             f_hit;
  logic             lookup_en;
  logic [31:0]      ret_target;
  logic [31:0]      hit_target;

  assign f_idx     = fetch_pc[IDX_W+1:2];
  assign f_tag     = fetch_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign f_hit     = v_tab[f_idx] && (tag_tab[f_idx] == f_tag);
  assign lookup_en = fetch_req && (state == RUN);

  // Training read port: sees the contents left by the previous update, so
  // back-to-back updates to one index chain their counters correctly.
  logic [IDX_W-1:0] u_idx;
  logic [TAG_W-1:0] u_tag;
  logic             u_hit, upd, is_jump, redirect;
  logic [1:0]       u_ctr, ctr_new;
  logic             wr_tgt, wr_alloc, wr_ctr, wr_ret;

  assign u_idx    = br_results.pc[IDX_W+1:2];
  assign u_tag    = br_results.pc[IDX_W+TAG_W+1:IDX_W+2];
  assign u_hit    = v_tab[u_idx] && (tag_tab[u_idx] == u_tag);
  assign u_ctr    = ctr_tab[u_idx];
  assign upd      = br_results.valid && (state == RUN);
  assign is_jump  = !br_results.is_branch;
  assign redirect = is_jump || br_results.branch_taken;

  // Targets change on any redirect; a not-taken branch only moves its
  // counter (on a hit) or does nothing (on a miss).
  assign wr_tgt   = upd && redirect;
  assign wr_alloc = upd && !u_hit && redirect;
  assign wr_ctr   = upd && (u_hit || redirect);
  assign wr_ret   = upd && redirect && (!u_hit || is_jump);

  always_comb begin
    ctr_new = u_ctr;
    if (is_jump)                      ctr_new = 2'd3;
    else if (!u_hit)                  ctr_new = 2'd2;
    else if (br_results.branch_taken) ctr_new = (u_ctr == 2'd3) ? 2'd3 : u_ctr + 2'd1;
    else                              ctr_new = (u_ctr == 2'd0) ? 2'd0 : u_ctr - 2'd1;
  end

  // Valid bits are cleared by the init sweep rather than by rst directly.
  always_ff @(posedge clk) begin
    if (clear_en)      v_tab[sweep_cnt] <= 1'b0;
    else if (wr_alloc) v_tab[u_idx]     <= 1'b1;
  end

  // NOTE: payload arrays have no reset; they are only read behind a valid
  // bit, which keeps them plain RAM.
  always_ff @(posedge clk) begin
    if (wr_alloc) begin
      tag_tab[u_idx] <= u_tag;
      br_tab[u_idx]  <= br_results.is_branch;
    end
    if (wr_tgt) tgt_tab[u_idx] <= br_results.target_pc[31:1];
    if (wr_ctr) ctr_tab[u_idx] <= ctr_new;
    if (wr_ret) ret_tab[u_idx] <= br_results.is_return;
  end

`ifdef BTB_RAS_EN
  // ---------------------------------------------------------------- return stack
  localparam int RAS_PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W  = $clog2(RAS_DEPTH + 1);

  logic [31:0]       ras_mem [RAS_DEPTH];
  logic [RAS_PW-1:0] ras_sp, sp_pop, sp_push;
  logic [CNT_W-1:0]  ras_cnt, cnt_pop, cnt_push;
  logic              do_pop, do_push;

  // A pop on an empty stack is dropped, leaving the pointer at empty.
  assign do_pop  = upd && br_results.is_return && (ras_cnt != '0);
  assign do_push = upd && br_results.is_call;

  // Pop first, then push, so a call+return packet replaces the top.
  always_comb begin
    sp_pop   = ras_sp;
    cnt_pop  = ras_cnt;
    if (do_pop) begin
      sp_pop  = (ras_sp == '0) ? RAS_PW'(RAS_DEPTH - 1) : ras_sp - 1'b1;
      cnt_pop = ras_cnt - 1'b1;
    end
    sp_push  = (sp_pop == RAS_PW'(RAS_DEPTH - 1)) ? '0 : sp_pop + 1'b1;
    // At full depth the push lands on the oldest slot, overwriting it.
    cnt_push = (cnt_pop == CNT_W'(RAS_DEPTH)) ? cnt_pop : cnt_pop + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ras_sp  <= '0;
      ras_cnt <= '0;
    end else if (do_push) begin
      ras_sp  <= sp_push;
      ras_cnt <= cnt_push;
    end else begin
      ras_sp  <= sp_pop;
      ras_cnt <= cnt_pop;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) ras_mem[sp_push] <= br_results.pc + 32'd4;
  end

  assign ret_target = (ras_cnt != '0) ? ras_mem[ras_sp] : 32'd0;
`else
  assign ret_target = {tgt_tab[f_idx], 1'b0};
`endif

  assign hit_target = ret_tab[f_idx] ? ret_target : {tgt_tab[f_idx], 1'b0};

  // ---------------------------------------------------------------- outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      init_done      <= 1'b0;
      pred_valid     <= 1'b0;
      pred_hit       <= 1'b0;
      pred_taken     <= 1'b0;
      pred_target    <= '0;
      pred_is_return <= 1'b0;
    end else begin
      init_done      <= (state == RUN);
      pred_valid     <= lookup_en;
      pred_hit       <= lookup_en && f_hit;
      pred_taken     <= lookup_en && f_hit && (!br_tab[f_idx] || ctr_tab[f_idx][1]);
      pred_target    <= (lookup_en && f_hit) ? hit_target : 32'd0;
      pred_is_return <= lookup_en && f_hit && ret_tab[f_idx];
    end
  end

  // Fields and address bits that carry no information for this table.
  logic unused_bits;
  assign unused_bits = ^{br_results.id, br_results.is_call, br_results.target_pc[0],
                         br_results.pc[1:0], br_results.pc[31:IDX_W+TAG_W+2],
                         fetch_pc[1:0], fetch_pc[31:IDX_W+TAG_W+2]};

endmodule

// File: tb/tb_branch_target_buffer.sv
// -----------------------------------------------------------------------------
// tb_branch_target_buffer
//
// Scoreboard bench for branch_target_buffer. Each lookup pushes its
// hand-computed prediction into a queue; an independent monitor pops and
// compares whenever the DUT raises pred_valid.
// -----------------------------------------------------------------------------
module tb_branch_target_buffer;
  import btb_pkg::*;

  localparam int ENTRIES = 512;

  typedef struct packed {
    logic        hit;
    logic        taken;
    logic [31:0] target;
    logic        is_ret;
  } pred_t;

  localparam pred_t MISS = '0;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            init_done;
  logic            fetch_req = 1'b0;
  logic [31:0]     fetch_pc = '0;
  logic            pred_valid, pred_hit, pred_taken, pred_is_return;
  logic [31:0]     pred_target;
  branch_results_t br_results = '0;

  int    vectors = 0;
  int    miscompares = 0;
  bit    mon_en = 1'b0;
  pred_t exp_q[$];
  logic [31:0] pc_q[$];

  branch_target_buffer #(.ENTRIES(ENTRIES), .TAG_W(8), .RAS_DEPTH(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .init_done      (init_done),
    .fetch_req      (fetch_req),
    .fetch_pc       (fetch_pc),
    .pred_valid     (pred_valid),
    .pred_hit       (pred_hit),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .pred_is_return (pred_is_return),
    .br_results     (br_results)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: outputs are sampled on the falling edge, away from the update.
  always @(negedge clk) begin
    if (mon_en && pred_valid) begin
      if (exp_q.size() == 0) begin
        check("pred_valid without request", pred_valid, 1'b0);
      end else begin
        pred_t       e;
        logic [31:0] p;
        e = exp_q.pop_front();
        p = pc_q.pop_front();
        check($sformatf("lookup pc=%08h {hit,taken,target,ret}", p),
              {pred_hit, pred_taken, pred_target, pred_is_return}, e);
      end
    end
  end

  function automatic branch_results_t pkt(input logic [31:0] pc, input logic [31:0] tgt,
                                          input logic taken, input logic is_br,
                                          input logic is_ret, input logic is_call);
    branch_results_t b;
    b = '0;
    b.valid        = 1'b1;
    b.pc           = pc;
    b.target_pc    = tgt;
    b.branch_taken = taken;
    b.is_branch    = is_br;
    b.is_return    = is_ret;
    b.is_call      = is_call;
    return b;
  endfunction

  function automatic pred_t pr(input logic taken, input logic [31:0] tgt, input logic ret);
    pred_t p;
    p.hit    = 1'b1;
    p.taken  = taken;
    p.target = tgt;
    p.is_ret = ret;
    return p;
  endfunction

  // One cycle of stimulus; a lookup also posts its expectation.
  task automatic step(input logic req, input logic [31:0] pc, input pred_t exp,
                      input branch_results_t b);
    @(negedge clk);
    fetch_req  = req;
    fetch_pc   = pc;
    br_results = b;
    if (req) begin
      exp_q.push_back(exp);
      pc_q.push_back(pc);
    end
  endtask

  task automatic upd(input branch_results_t b);
    step(1'b0, 32'd0, MISS, b);
  endtask

  task automatic look(input logic [31:0] pc, input pred_t exp);
    step(1'b1, pc, exp, '0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'd0, MISS, '0);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    fetch_req  = 1'b0;
    br_results = '0;
    repeat (cycles) @(negedge clk);
    check("reset state {init_done,pred_*}",
          {init_done, pred_valid, pred_hit, pred_taken, pred_target, pred_is_return}, '0);
    rst = 1'b0;
  endtask

  // Counts falling edges from rst deassertion until init_done. Lookups and a
  // training packet are held active during the sweep; both must be ignored.
  task automatic wait_init(input string name);
    int n;
    bit quiet;
    n     = 0;
    quiet = 1'b1;
    fetch_req  = 1'b1;
    fetch_pc   = 32'h300;
    br_results = pkt(32'h300, 32'h380, 1'b1, 1'b1, 1'b0, 1'b0);
    while (n < 2 * ENTRIES + 10) begin
      @(negedge clk);
      n++;
      if (init_done) break;
      if (pred_valid || pred_hit || pred_taken || pred_target != 0 || pred_is_return)
        quiet = 1'b0;
      // The FSM has just entered RUN; stop driving so nothing is trained.
      if (n == ENTRIES) begin
        fetch_req  = 1'b0;
        br_results = '0;
      end
    end
    check({name, " init_done latency"}, n, ENTRIES + 1);
    check({name, " pred_* quiet during sweep"}, quiet, 1'b1);
    fetch_req  = 1'b0;
    br_results = '0;
  endtask

  initial begin
    do_reset(2);
    wait_init("first");
    idle(2);
    mon_en = 1'b1;

    // Training packet held during the sweep left nothing behind.
    look(32'h300, MISS);

    // Miss + taken branch allocates with ctr=2.
    upd(pkt(32'h100, 32'h200, 1'b1, 1'b1, 1'b0, 1'b0));
    look(32'h100, pr(1'b1, 32'h200, 1'b0));

    // Two not-taken: 2->1->0; target untouched by not-taken updates.
    upd(pkt(32'h100, 32'h2f0, 1'b0, 1'b1, 1'b0, 1'b0));
    upd(pkt(32'h100, 32'h2f0, 1'b0, 1'b1, 1'b0, 1'b0));
    look(32'h100, pr(1'b0, 32'h200, 1'b0));

    // Saturate at 0, then one taken -> 1 (still not taken, target rewritten).
    upd(pkt(32'h100, 32'h2f0, 1'b0, 1'b1, 1'b0, 1'b0));
    upd(pkt(32'h100, 32'h240, 1'b1, 1'b1, 1'b0, 1'b0));
    look(32'h100, pr(1'b0, 32'h240, 1'b0));

    // 1->2->3->3(sat), then not-taken -> 2: taken.
    upd(pkt(32'h100, 32'h240, 1'b1, 1'b1, 1'b0, 1'b0));
    upd(pkt(32'h100, 32'h240, 1'b1, 1'b1, 1'b0, 1'b0));
    upd(pkt(32'h100, 32'h240, 1'b1, 1'b1, 1'b0, 1'b0));
    upd(pkt(32'h100, 32'h240, 1'b0, 1'b1, 1'b0, 1'b0));
    look(32'h100, pr(1'b1, 32'h240, 1'b0));

    // Same-cycle lookup and update sees pre-update contents; pc[1:0] ignored.
    step(1'b1, 32'h500, MISS, pkt(32'h500, 32'h600, 1'b1, 1'b1, 1'b0, 1'b0));
    look(32'h502, pr(1'b1, 32'h600, 1'b0));

    // Aliasing jump at 0x100 + 4*ENTRIES replaces the 0x100 entry.
    upd(pkt(32'h100 + 4 * ENTRIES, 32'h1234, 1'b0, 1'b0, 1'b0, 1'b0));
    look(32'h100, MISS);
    look(32'h100 + 4 * ENTRIES, pr(1'b1, 32'h1234, 1'b0));

    // Return entry installed by a jump with is_return.
    upd(pkt(32'ha00, 32'h3000, 1'b0, 1'b0, 1'b1, 1'b0));
`ifdef BTB_RAS_EN
    // The return's own resolution pops (empty, dropped); then the call pushes
    // 0x404, which the return hit must predict.
    upd(pkt(32'h400, 32'h7000, 1'b0, 1'b0, 1'b0, 1'b1));
    look(32'ha00, pr(1'b1, 32'h404, 1'b1));
    look(32'h400, pr(1'b1, 32'h7000, 1'b0));
`else
    look(32'ha00, pr(1'b1, 32'h3000, 1'b1));
`endif

    // Hit jump rewrites target and refreshes is_return.
    upd(pkt(32'ha00, 32'h3100, 1'b0, 1'b0, 1'b0, 1'b0));
    look(32'ha00, pr(1'b1, 32'h3100, 1'b0));

    // Miss + not-taken branch does not allocate.
    upd(pkt(32'h700, 32'h780, 1'b0, 1'b1, 1'b0, 1'b0));
    look(32'h700, MISS);

    idle(3);
    check("queue drained before reset", exp_q.size(), 0);

    // Mid-run reset restarts the sweep and wipes every entry.
    mon_en = 1'b0;
    do_reset(1);
    wait_init("restart");
    idle(2);
    mon_en = 1'b1;
    look(32'h100 + 4 * ENTRIES, MISS);
    look(32'h500, MISS);
    idle(3);
    check("queue drained at end", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
